// File: rtl/event_packetizer.sv
// event_packetizer: captures granted pixel events from the row/column
// arbiter pair into timestamped packets, buffers them in a synchronous
// FIFO and drains them over a valid/ready interface. The arbiters are
// throttled early enough that the one in-flight registered grant always
// finds a free slot.
module event_packetizer #(
  parameter  int unsigned X_W   = 3,
  parameter  int unsigned Y_W   = 3,
  parameter  int unsigned TS_W  = 16,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned PKT_W = TS_W + X_W + Y_W + 1
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       evt_valid_i,
  input  logic [X_W-1:0]             xadd_i,
  input  logic [Y_W-1:0]             yadd_i,
  input  logic                       polarity_i,
  input  logic                       pkt_ready_i,
  output logic                       pkt_valid_o,
  output logic [PKT_W-1:0]           pkt_data_o,
  output logic                       arb_enable_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic                       overflow_o,
  output logic [7:0]                 drop_cnt_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [TS_W-1:0]  ts_q;
  logic [PKT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             overflow_q;
  logic [7:0]       drop_q;

  logic empty;
  logic full;
  logic push;
  logic pop;
  logic drop;

  // Handshake decode: a pop frees a slot for a same-cycle push even when full
  always_comb begin
    empty = (count_q == '0);
    full  = (count_q == CNT_W'(DEPTH));
    pop   = ~empty & pkt_ready_i;
    push  = evt_valid_i & (~full | pop);
    drop  = evt_valid_i & full & ~pop;
  end

  // Free-running timestamp, wraps silently
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_q + TS_W'(1);
    end
  end

  // FIFO storage, pointers and occupancy; memory cleared so the head reads zero after reset
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[PTR_W'(i)] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr_q] <= {ts_q, xadd_i, yadd_i, polarity_i};
        wr_ptr_q      <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky overflow flag and saturating drop counter
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (drop_q != 8'hFF) begin
        drop_q <= drop_q + 8'd1;
      end
    end
  end

  // Output mapping; throttle at DEPTH-1 leaves room for the registered in-flight grant
  always_comb begin
    pkt_valid_o  = ~empty;
    pkt_data_o   = mem[rd_ptr_q];
    arb_enable_o = (count_q < CNT_W'(DEPTH - 1));
    count_o      = count_q;
    full_o       = full;
    empty_o      = empty;
    overflow_o   = overflow_q;
    drop_cnt_o   = drop_q;
  end

endmodule

// File: tb/tb_event_packetizer.sv
// Directed testbench for event_packetizer with hand-computed expectations.
module tb_event_packetizer;

  localparam int X_W   = 3;
  localparam int Y_W   = 3;
  localparam int TS_W  = 16;
  localparam int DEPTH = 8;
  localparam int PKT_W = 23;

  logic             clk_i = 1'b0;
  logic             reset_i = 1'b0;
  logic             evt_valid_i = 1'b0;
  logic [2:0]       xadd_i = '0;
  logic [2:0]       yadd_i = '0;
  logic             polarity_i = 1'b0;
  logic             pkt_ready_i = 1'b0;
  logic             pkt_valid_o;
  logic [PKT_W-1:0] pkt_data_o;
  logic             arb_enable_o;
  logic [3:0]       count_o;
  logic             full_o;
  logic             empty_o;
  logic             overflow_o;
  logic [7:0]       drop_cnt_o;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0]      tb_ts = '0;
  logic [PKT_W-1:0] sb [$];
  logic [PKT_W-1:0] exp_pkt;

  always #5 clk_i = ~clk_i;

  // Independent timestamp reference: value of the counter during the current cycle
  always @(posedge clk_i) begin
    if (!reset_i) tb_ts <= '0;
    else          tb_ts <= tb_ts + 16'd1;
  end

  event_packetizer #(
    .X_W   (X_W),
    .Y_W   (Y_W),
    .TS_W  (TS_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .evt_valid_i  (evt_valid_i),
    .xadd_i       (xadd_i),
    .yadd_i       (yadd_i),
    .polarity_i   (polarity_i),
    .pkt_ready_i  (pkt_ready_i),
    .pkt_valid_o  (pkt_valid_o),
    .pkt_data_o   (pkt_data_o),
    .arb_enable_o (arb_enable_o),
    .count_o      (count_o),
    .full_o       (full_o),
    .empty_o      (empty_o),
    .overflow_o   (overflow_o),
    .drop_cnt_o   (drop_cnt_o)
  );

  function automatic logic [PKT_W-1:0] mk(input logic [15:0] ts, input logic [2:0] x,
                                          input logic [2:0] y, input logic p);
    return {ts, x, y, p};
  endfunction

  task automatic test_reset();
    @(negedge clk_i);
    reset_i = 1'b0; evt_valid_i = 1'b0; pkt_ready_i = 1'b0;
    repeat (2) @(negedge clk_i);
    reset_i = 1'b1;
    @(negedge clk_i);
    n_vec++; if (count_o !== 4'd0) begin n_err++; $display("FAIL rst_count got=%0d exp=0", count_o); end
    n_vec++; if (pkt_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_valid got=%b exp=0", pkt_valid_o); end
    n_vec++; if (empty_o !== 1'b1) begin n_err++; $display("FAIL rst_empty got=%b exp=1", empty_o); end
    n_vec++; if (full_o !== 1'b0) begin n_err++; $display("FAIL rst_full got=%b exp=0", full_o); end
    n_vec++; if (arb_enable_o !== 1'b1) begin n_err++; $display("FAIL rst_arb_en got=%b exp=1", arb_enable_o); end
    n_vec++; if (overflow_o !== 1'b0) begin n_err++; $display("FAIL rst_overflow got=%b exp=0", overflow_o); end
    n_vec++; if (drop_cnt_o !== 8'd0) begin n_err++; $display("FAIL rst_drop got=%0d exp=0", drop_cnt_o); end
    n_vec++; if (pkt_data_o !== 23'd0) begin n_err++; $display("FAIL rst_data got=%h exp=0", pkt_data_o); end
    repeat (4) @(negedge clk_i);
    evt_valid_i = 1'b1; xadd_i = 3'd2; yadd_i = 3'd6; polarity_i = 1'b0;
    @(negedge clk_i);
    evt_valid_i = 1'b0;
    exp_pkt = {16'd5, 3'd2, 3'd6, 1'b0};
    n_vec++; if (pkt_valid_o !== 1'b1 || pkt_data_o !== exp_pkt) begin
      n_err++; $display("FAIL rst_ts5 got valid=%b data=%h exp valid=1 data=%h", pkt_valid_o, pkt_data_o, exp_pkt); end
    pkt_ready_i = 1'b1;
    @(negedge clk_i);
    pkt_ready_i = 1'b0;
    n_vec++; if (pkt_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_drain got=%b exp=0", pkt_valid_o); end
  endtask

  task automatic test_single_event();
    reset_i = 1'b0;
    @(negedge clk_i);
    reset_i = 1'b1;
    repeat (10) @(negedge clk_i);
    pkt_ready_i = 1'b1;
    evt_valid_i = 1'b1; xadd_i = 3'd3; yadd_i = 3'd5; polarity_i = 1'b1;
    @(negedge clk_i);
    evt_valid_i = 1'b0;
    exp_pkt = {16'd10, 3'd3, 3'd5, 1'b1};
    n_vec++; if (pkt_valid_o !== 1'b1) begin n_err++; $display("FAIL single_valid got=%b exp=1", pkt_valid_o); end
    n_vec++; if (pkt_data_o !== exp_pkt) begin n_err++; $display("FAIL single_data got=%h exp=%h", pkt_data_o, exp_pkt); end
    n_vec++; if (count_o !== 4'd1) begin n_err++; $display("FAIL single_count got=%0d exp=1", count_o); end
    @(negedge clk_i);
    pkt_ready_i = 1'b0;
    n_vec++; if (pkt_valid_o !== 1'b0 || empty_o !== 1'b1) begin
      n_err++; $display("FAIL single_gone got valid=%b empty=%b exp valid=0 empty=1", pkt_valid_o, empty_o); end
  endtask

  task automatic test_backpressure_fill();
    logic en_prev = 1'b1;
    int   fell_cnt = -1;
    sb.delete();
    pkt_ready_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!arb_enable_o && fell_cnt < 0) fell_cnt = int'(count_o);
      evt_valid_i = en_prev;
      xadd_i = i[2:0]; yadd_i = ~i[2:0]; polarity_i = i[0];
      if (evt_valid_i) sb.push_back(mk(tb_ts, xadd_i, yadd_i, polarity_i));
      en_prev = arb_enable_o;
      @(negedge clk_i);
    end
    evt_valid_i = 1'b0;
    n_vec++; if (fell_cnt !== 7) begin n_err++; $display("FAIL fill_en_fall got_count=%0d exp=7", fell_cnt); end
    n_vec++; if (count_o !== 4'd8) begin n_err++; $display("FAIL fill_count got=%0d exp=8", count_o); end
    n_vec++; if (full_o !== 1'b1) begin n_err++; $display("FAIL fill_full got=%b exp=1", full_o); end
    n_vec++; if (arb_enable_o !== 1'b0) begin n_err++; $display("FAIL fill_arb_en got=%b exp=0", arb_enable_o); end
    n_vec++; if (overflow_o !== 1'b0) begin n_err++; $display("FAIL fill_overflow got=%b exp=0", overflow_o); end
    n_vec++; if (drop_cnt_o !== 8'd0) begin n_err++; $display("FAIL fill_drop got=%0d exp=0", drop_cnt_o); end
    n_vec++; if (pkt_data_o !== sb[0]) begin n_err++; $display("FAIL fill_head got=%h exp=%h", pkt_data_o, sb[0]); end
  endtask

  task automatic test_overflow();
    pkt_ready_i = 1'b0;
    evt_valid_i = 1'b1; xadd_i = 3'd7; yadd_i = 3'd7; polarity_i = 1'b1;
    repeat (3) @(negedge clk_i);
    evt_valid_i = 1'b0;
    n_vec++; if (overflow_o !== 1'b1) begin n_err++; $display("FAIL ovf_flag got=%b exp=1", overflow_o); end
    n_vec++; if (drop_cnt_o !== 8'd3) begin n_err++; $display("FAIL ovf_drop got=%0d exp=3", drop_cnt_o); end
    n_vec++; if (count_o !== 4'd8) begin n_err++; $display("FAIL ovf_count got=%0d exp=8", count_o); end
    n_vec++; if (pkt_data_o !== sb[0]) begin n_err++; $display("FAIL ovf_head got=%h exp=%h", pkt_data_o, sb[0]); end
  endtask

  task automatic test_full_push_pop();
    pkt_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_pkt = sb.pop_front();
      n_vec++; if (pkt_valid_o !== 1'b1 || pkt_data_o !== exp_pkt) begin
        n_err++; $display("FAIL fpp_head%0d got valid=%b data=%h exp=%h", i, pkt_valid_o, pkt_data_o, exp_pkt); end
      evt_valid_i = 1'b1; xadd_i = 3'(i + 1); yadd_i = 3'(i + 4); polarity_i = ~i[0];
      sb.push_back(mk(tb_ts, xadd_i, yadd_i, polarity_i));
      @(negedge clk_i);
    end
    evt_valid_i = 1'b0;
    n_vec++; if (count_o !== 4'd8) begin n_err++; $display("FAIL fpp_count got=%0d exp=8", count_o); end
    n_vec++; if (drop_cnt_o !== 8'd3) begin n_err++; $display("FAIL fpp_drop got=%0d exp=3", drop_cnt_o); end
    for (int i = 0; i < 8; i++) begin
      exp_pkt = sb.pop_front();
      n_vec++; if (pkt_valid_o !== 1'b1 || pkt_data_o !== exp_pkt) begin
        n_err++; $display("FAIL drain%0d got valid=%b data=%h exp=%h", i, pkt_valid_o, pkt_data_o, exp_pkt); end
      @(negedge clk_i);
    end
    pkt_ready_i = 1'b0;
    n_vec++; if (empty_o !== 1'b1 || arb_enable_o !== 1'b1) begin
      n_err++; $display("FAIL drain_empty got empty=%b en=%b exp 1 1", empty_o, arb_enable_o); end
    n_vec++; if (overflow_o !== 1'b1) begin n_err++; $display("FAIL drain_ovf_sticky got=%b exp=1", overflow_o); end
  endtask

  task automatic test_wrap_and_reset();
    pkt_ready_i = 1'b0;
    for (int k = 0; k < 70000 && tb_ts !== 16'hFFFF; k++) @(negedge clk_i);
    n_vec++; if (tb_ts !== 16'hFFFF) begin n_err++; $display("FAIL wrap_timeout got=%h exp=ffff", tb_ts); end
    for (int i = 0; i < 6; i++) begin
      evt_valid_i = 1'b1; xadd_i = i[2:0]; yadd_i = 3'd7 - i[2:0]; polarity_i = i[0];
      @(negedge clk_i);
    end
    evt_valid_i = 1'b0;
    exp_pkt = {16'hFFFF, 3'd0, 3'd7, 1'b0};
    n_vec++; if (pkt_data_o !== exp_pkt) begin n_err++; $display("FAIL wrap_ffff got=%h exp=%h", pkt_data_o, exp_pkt); end
    n_vec++; if (count_o !== 4'd6) begin n_err++; $display("FAIL wrap_count6 got=%0d exp=6", count_o); end
    pkt_ready_i = 1'b1;
    @(negedge clk_i);
    pkt_ready_i = 1'b0;
    exp_pkt = {16'h0000, 3'd1, 3'd6, 1'b1};
    n_vec++; if (pkt_data_o !== exp_pkt) begin n_err++; $display("FAIL wrap_0000 got=%h exp=%h", pkt_data_o, exp_pkt); end
    n_vec++; if (count_o !== 4'd5) begin n_err++; $display("FAIL wrap_count5 got=%0d exp=5", count_o); end
    reset_i = 1'b0; pkt_ready_i = 1'b1;
    @(negedge clk_i);
    n_vec++; if (count_o !== 4'd0 || pkt_valid_o !== 1'b0 || empty_o !== 1'b1) begin
      n_err++; $display("FAIL midrst_flush got count=%0d valid=%b empty=%b exp 0 0 1", count_o, pkt_valid_o, empty_o); end
    n_vec++; if (pkt_data_o !== 23'd0) begin n_err++; $display("FAIL midrst_data got=%h exp=0", pkt_data_o); end
    n_vec++; if (overflow_o !== 1'b0 || drop_cnt_o !== 8'd0) begin
      n_err++; $display("FAIL midrst_ovf got ovf=%b drop=%0d exp 0 0", overflow_o, drop_cnt_o); end
    reset_i = 1'b1; pkt_ready_i = 1'b0;
    repeat (3) @(negedge clk_i);
    evt_valid_i = 1'b1; xadd_i = 3'd1; yadd_i = 3'd2; polarity_i = 1'b1;
    @(negedge clk_i);
    evt_valid_i = 1'b0;
    exp_pkt = {16'd3, 3'd1, 3'd2, 1'b1};
    n_vec++; if (pkt_valid_o !== 1'b1 || pkt_data_o !== exp_pkt) begin
      n_err++; $display("FAIL midrst_ts got valid=%b data=%h exp=%h", pkt_valid_o, pkt_data_o, exp_pkt); end
    n_vec++; if (count_o !== 4'd1) begin n_err++; $display("FAIL midrst_count got=%0d exp=1", count_o); end
  endtask

  task automatic test_drop_saturate();
    pkt_ready_i = 1'b0;
    evt_valid_i = 1'b1; xadd_i = 3'd5; yadd_i = 3'd3; polarity_i = 1'b0;
    repeat (268) @(negedge clk_i);
    evt_valid_i = 1'b0;
    n_vec++; if (drop_cnt_o !== 8'd255) begin n_err++; $display("FAIL sat_drop got=%0d exp=255", drop_cnt_o); end
    n_vec++; if (count_o !== 4'd8 || overflow_o !== 1'b1) begin
      n_err++; $display("FAIL sat_state got count=%0d ovf=%b exp 8 1", count_o, overflow_o); end
  endtask

  initial begin
    test_reset();
    test_single_event();
    test_backpressure_fill();
    test_overflow();
    test_full_push_pop();
    test_wrap_and_reset();
    test_drop_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/event_packetizer.md
# event_packetizer

Downstream stage of the row/column round-robin arbiter pair in the event-based-camera readout. Each cycle the column arbiter presents a registered grant, `event_packetizer` captures the granted pixel's row address, column address, polarity and a free-running timestamp into a single packet. It buffers packets in a synchronous FIFO and drains them over a valid/ready interface. It also throttles the arbiter through `arb_enable_o`, so that under legal operation no granted event is lost.

## Interface
- `X_W`, 3: row-address width (`xadd_i`).
- `Y_W`, 3: column-address width (`yadd_i`).
- `TS_W`, 16: timestamp counter width.
- `DEPTH`, 8: FIFO entries; power of two, ≥ 4.
- `PKT_W`, derived = `TS_W+X_W+Y_W+1`: packet width.

Ports:
- `clk_i`  in  1  single clock; all state updates on rising edge.
- `reset_i`  in  1  synchronous, active-low reset (sampled on `clk_i` rising edge while 0).
- `evt_valid_i`  in  1  OR-reduction of the column arbiter's registered grant vector; 1 = a granted event is present this cycle.
- `xadd_i`  in  `X_W`  row address of the active row.
- `yadd_i`  in  `Y_W`  column address from the column arbiter.
- `polarity_i`  in  1  polarity of the granted pixel (1 = ON, 0 = OFF).
- `pkt_ready_i`  in  1  downstream ready.
- `pkt_valid_o`  out  1  FIFO head is valid.
- `pkt_data_o`  out  `PKT_W`  head packet, packed as {timestamp, xadd, yadd, polarity}, MSB first.
- `arb_enable_o`  out  1  enable to the row/column arbiters.
- `count_o`  out  `$clog2(DEPTH)+1`  current FIFO occupancy.
- `full_o`, `empty_o`  out  1 each  occupancy flags.
- `overflow_o`  out  1  sticky flag; set on a dropped event.
- `drop_cnt_o`  out  8  dropped-event counter; saturates at 255.

## Operation
- **Timestamp counter.**
  - `TS_W` bits, increments by 1 every cycle after reset.
  - Wraps from all-ones to 0 with no flag.
  - The packet carries the counter value in the cycle the event is written.
- **Push and pop conditions.**
  - push = `evt_valid_i` & (~`full_o` | pop).
  - pop = `pkt_valid_o` & `pkt_ready_i`.
- **FIFO storage.**
  - Circular buffer with read and write pointers of `$clog2(DEPTH)` bits; both wrap modulo `DEPTH`.
  - `count_o` is updated as +1 (push only), −1 (pop only), or unchanged (both or neither).
- **Flags and head output.**
  - `pkt_valid_o` = ~`empty_o`.
  - `pkt_data_o` = mem[rd_ptr].
  - `pkt_data_o` must hold stable while `pkt_valid_o` & ~`pkt_ready_i`.
- **Drops.**
  - A drop occurs when `evt_valid_i` & `full_o` & ~pop; the event is discarded.
  - On a drop, `overflow_o` is set and `drop_cnt_o` increments, saturating at 255.
  - `overflow_o` clears only on reset.
- **Arbiter throttle.**
  - `arb_enable_o` = (`count_o` < `DEPTH`−1), combinational from registered count.
  - The arbiter's grant is registered, so one further event can arrive after `arb_enable_o` falls. The threshold of `DEPTH`−1 leaves exactly one slot for that in-flight event, so no drop occurs under legal operation.
- **No bypass.** An event written into an empty FIFO appears on `pkt_valid_o` one cycle later.

## Timing
- **Reset values** (`reset_i`=0 at an edge):
  - pointers, count, timestamp, `drop_cnt_o` = 0.
  - `overflow_o` = 0, `pkt_valid_o` = 0, `empty_o` = 1, `full_o` = 0, `arb_enable_o` = 1.
  - `pkt_data_o` = 0, because the memory is cleared on reset.
- **Mid-operation reset.** Reset asserted mid-operation discards all buffered packets in that same edge. No partial pop is visible.
- **Write-to-output latency.**
  - Event at edge N → `pkt_valid_o` = 1 after edge N+1.
  - Its timestamp field equals the counter value during cycle N.
- **Handshake.**
  - The head retires on the edge where `pkt_valid_o` & `pkt_ready_i`.
  - Throughput is one packet per cycle in and out.
- **Simultaneous push and pop when full.** Both are accepted; count stays `DEPTH`; no drop.
- **Simultaneous push and pop when empty.** Pop is impossible because `pkt_valid_o` = 0, so count goes 0 → 1.
- **`arb_enable_o` update.** It follows count in the same cycle: low in any cycle with count ≥ `DEPTH`−1, high again once count ≤ `DEPTH`−2.

## Test plan
- **Reset.** Hold `reset_i`=0 for 2 cycles, then release with no events → all outputs at reset values and `arb_enable_o`=1. After 5 cycles the internal timestamp = 5, checked via the next packet's timestamp field.
- **Single event.**
  - Stimulus: `xadd_i`=3, `yadd_i`=5, `polarity_i`=1 at timestamp 10, with `pkt_ready_i`=1.
  - Response: next cycle `pkt_valid_o`=1 and `pkt_data_o` = {16'd10, 3'd3, 3'd5, 1'b1}; one cycle later `pkt_valid_o`=0.
- **Backpressure fill.**
  - Stimulus: `pkt_ready_i`=0 and `evt_valid_i`=1 continuously, with `evt_valid_i` driven low one cycle after `arb_enable_o` falls (arbiter model).
  - Response: `arb_enable_o` falls when count reaches 7; the in-flight event fills entry 8; `full_o`=1, `overflow_o`=0, `drop_cnt_o`=0.
- **Overflow.** While full with `pkt_ready_i`=0, force `evt_valid_i`=1 for 3 cycles → `overflow_o`=1, `drop_cnt_o`=3, count stays 8, and stored packets are unchanged.
- **Full push and pop.** While full, set `pkt_ready_i`=1 and `evt_valid_i`=1 for 4 cycles → 4 packets drain in order, count stays 8, `drop_cnt_o` is unchanged.
- **Timestamp wrap and mid-run reset.**
  - Timestamp wrap: events at timestamps 65535 and then 0 → packets carry 16'hFFFF then 16'h0000.
  - Mid-run reset: assert reset with 5 entries buffered → next cycle count=0 and `pkt_valid_o`=0; after release, the first new packet has the correct post-reset timestamp.
